pipe_step_ctrl: RTL and testbench
=================================

// Module: pipe_step_ctrl
// PURPOSE
//  Pipeline advance controller for the MIPS core. Replaces the hard SW17 manual/1 Hz clock mux with one
//  system clock plus a single-cycle advance enable (adv) that gates every pipeline register, PC and
//  regfile write. Supports free-run at a programmable rate, single-step, N-step burst and run-to-breakpoint.
//  Sits between the debounced KEY/SW inputs and the datapath; also owns the clock counter (cc).
// PARAMETERS
//  PC_W    16  width of program counter / breakpoint addresses
//  CNT_W   16  width of cycle counter and burst length
//  DIV_W   26  width of rate divider (50 MHz -> 1 Hz needs 26 bits)
//  NUM_BP  4   number of hardware breakpoints (1..8)
// PORTS
//  clock        in   1              system clock (CLOCK_50)
//  reset        in   1              asynchronous, active-low reset
//  mode         in   2              00 STEP, 01 RUN, 10 BURST, 11 RUN_TO_BP
//  step_req     in   1              debounced key level; rising edge = one request
//  halt_req     in   1              level; forces HALT while high
//  rate_div     in   DIV_W          adv period in RUN/RUN_TO_BP/BURST = rate_div+1 clocks
//  burst_len    in   CNT_W          advances per BURST request (0 treated as 1)
//  pc           in   PC_W           current PC from counter block
//  bp_addr      in   NUM_BP*PC_W    breakpoint addresses, slot i at [i*PC_W +: PC_W]
//  bp_en        in   NUM_BP         per-slot enable
//  adv          out  1              one-clock advance enable
//  running      out  1              1 in RUN or BURST states
//  bp_hit       out  1              sticky: halted on breakpoint; cleared on next request
//  bp_idx       out  3              lowest matching slot index, valid when bp_hit
//  cycle_cnt    out  CNT_W          count of adv pulses, wraps
// BEHAVIOUR
//  Reset: state IDLE; adv=0, running=0, bp_hit=0, bp_idx=0, cycle_cnt=0, prescaler=0, edge reg=0.
//  step_req edge: req = step_req & ~step_q (step_q registered); one req per press, no repeat.
//  Prescaler: counts 0..rate_div, tick=1 when count==rate_div then reloads 0; rate_div=0 -> tick every
//   clock. Prescaler held at 0 in IDLE/HALT so first adv after entry is rate_div+1 clocks later.
//  States:
//   IDLE : mode STEP & req -> adv=1 this+1 clock (registered), stay IDLE.
//          mode RUN -> RUN (no req needed). mode BURST & req -> BURST, remaining=max(burst_len,1).
//          mode RUN_TO_BP & req -> RUN.
//   RUN  : adv on each tick. If mode==RUN_TO_BP and tick and pc matches any enabled slot -> suppress adv,
//          set bp_hit, latch bp_idx, go HALT. Mode changes to STEP/BURST -> IDLE next clock.
//   BURST: adv on each tick, remaining-=1; remaining reaches 0 -> IDLE. Breakpoints not checked.
//          Mode change mid-burst aborts -> IDLE, no further adv.
//   HALT : adv=0. req -> clear bp_hit, issue exactly one adv (step off the breakpoint, no re-match on
//          that pc), then RUN. Mode==STEP or BURST -> IDLE (bp_hit kept until next req).
//  halt_req=1: from any state -> HALT next clock, adv=0 same clock it is sampled; highest priority over
//   req, tick and breakpoint. Release with req as above.
//  adv is registered (one clock after the deciding tick/req); never high two clocks in a row when
//   rate_div>0. cycle_cnt increments on every clock where adv=1; wraps 2^CNT_W-1 -> 0.
//  Breakpoint compare: combinational equality pc==bp_addr[i] & bp_en[i]; multiple hits -> lowest i.
//  Reset asserted mid-burst/run: immediate return to reset values, adv drops asynchronously.
// STRUCTURE
//  Shared package (mips_pkg): mode encodings MODE_STEP/RUN/BURST/RUN_TO_BP, state enum
//   ST_IDLE/ST_RUN/ST_BURST/ST_HALT.
//  One sub-module: rate_tick (DIV_W prescaler with hold input, outputs tick). Breakpoint compare and
//   priority encode inline via generate loop.
// TESTING
//  STEP, 3 req pulses spaced 10 clocks -> exactly 3 adv pulses, cycle_cnt=3, running=0 throughout.
//  RUN, rate_div=4, 50 clocks -> adv every 5th clock, first 5 clocks after entry, cycle_cnt=10.
//  BURST, burst_len=7, rate_div=0, one req -> 7 consecutive adv, then IDLE; burst_len=0 -> 1 adv.
//  RUN_TO_BP, bp_addr slot2=0x0010 en, pc ramps 0,4,8,... -> no adv when pc=0x0010, bp_hit=1,
//   bp_idx=2; next req -> one adv, bp_hit=0, resumes RUN; slots 1&2 both 0x0010 -> bp_idx=1.
//  halt_req during BURST (remaining=4) -> adv=0 from next clock, state HALT; req -> single adv, RUN.
//  reset low mid-RUN with cycle_cnt=0x00FF -> all outputs 0 immediately; cycle_cnt wrap 0xFFFF->0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the pipeline advance controller.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mips_pkg;

  // Operator-selected advance mode, as presented on the mode switches.
  typedef enum logic [1:0] {
    MODE_STEP      = 2'b00,
    MODE_RUN       = 2'b01,
    MODE_BURST     = 2'b10,
    MODE_RUN_TO_BP = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BURST = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  // Breakpoint slot index width (up to 8 slots).
  localparam int BP_IDX_W = 3;

  // RUN and RUN_TO_BP keep the core free-running; STEP and BURST are
  // request-driven and force the controller back to IDLE.
  function automatic logic is_free_mode(mode_e m);
    return (m == MODE_RUN) || (m == MODE_RUN_TO_BP);
  endfunction

endpackage

// File: rtl/pipe_step_ctrl_rate_tick.sv
// Rate prescaler: one-clock tick every rate_div+1 clocks while not held.
// Latency: tick is combinational from the count; first tick rate_div clocks after hold drops.
// Backpressure: none; hold forces the count to 0 and suppresses tick.
//
// Ports:
//   clock, reset   system clock, async active-low reset
//   hold           1 = clear and freeze the prescaler
//   rate_div       terminal count (period = rate_div+1 clocks)
//   tick           1 on the clock the count reaches rate_div
module rate_tick #(
  parameter int DIV_W = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  input  logic [DIV_W-1:0] rate_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // '>=' rather than '==' so that lowering rate_div below the current
  // count reloads immediately instead of running the counter around.
  always_comb begin
    tick  = ~hold && (cnt_q >= rate_div);
    cnt_d = (hold || tick) ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_step_ctrl.sv
// Pipeline advance controller: one-clock adv enable for step / run / burst / run-to-breakpoint.
// Latency: adv is registered, one clock after the deciding request or prescaler tick.
// Backpressure: halt_req forces HALT and masks adv in the same clock; no other stalls.
//
// Ports:
//   clock, reset        system clock, async active-low reset
//   mode                00 STEP, 01 RUN, 10 BURST, 11 RUN_TO_BP
//   step_req            debounced key level, rising edge = one request
//   halt_req            level, holds the controller in HALT
//   rate_div            adv period in free-run / burst = rate_div+1 clocks
//   burst_len           advances per BURST request (0 behaves as 1)
//   pc                  current PC, compared against breakpoints
//   bp_addr, bp_en      breakpoint slots, slot i at [i*PC_W +: PC_W]
//   adv                 one-clock advance enable for the datapath
//   running             1 in RUN or BURST
//   bp_hit, bp_idx      sticky breakpoint halt flag and lowest matching slot
//   cycle_cnt           number of adv pulses, wrapping
module pipe_step_ctrl
  import mips_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 26,
  parameter int NUM_BP = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   step_req,
  input  logic                   halt_req,
  input  logic [DIV_W-1:0]       rate_div,
  input  logic [CNT_W-1:0]       burst_len,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   adv,
  output logic                   running,
  output logic                   bp_hit,
  output logic [BP_IDX_W-1:0]    bp_idx,
  output logic [CNT_W-1:0]       cycle_cnt
);

  state_e              state_q, state_d;
  logic                adv_q, adv_d;
  logic                step_q;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                bp_hit_q, bp_hit_d;
  logic [BP_IDX_W-1:0] bp_idx_q, bp_idx_d;
  logic [CNT_W-1:0]    adv_cnt_q;

  mode_e               mode_m;
  logic                req;
  logic                tick;
  logic                hold;
  logic [NUM_BP-1:0]   bp_match;
  logic                bp_any;
  logic [BP_IDX_W-1:0] bp_first;

  assign mode_m = mode_e'(mode);
  assign req    = step_req & ~step_q;

  // Prescaler restarts from 0 on every entry into RUN/BURST.
  assign hold = (state_q == ST_IDLE) || (state_q == ST_HALT);

  rate_tick #(.DIV_W(DIV_W)) u_rate_tick (
    .clock    (clock),
    .reset    (reset),
    .hold     (hold),
    .rate_div (rate_div),
    .tick     (tick)
  );

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    assign bp_match[i] = bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W]);
  end

  assign bp_any = |bp_match;

  // Scan high to low so the lowest matching slot wins.
  always_comb begin
    bp_first = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_match[i]) bp_first = BP_IDX_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    adv_d    = 1'b0;
    rem_d    = rem_q;
    bp_hit_d = bp_hit_q;
    bp_idx_d = bp_idx_q;

    if (halt_req) begin
      state_d = ST_HALT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req) bp_hit_d = 1'b0;
          unique case (mode_m)
            MODE_STEP:      adv_d = req;
            MODE_RUN:       state_d = ST_RUN;
            MODE_BURST: begin
              if (req) begin
                state_d = ST_BURST;
                rem_d   = (burst_len == '0) ? CNT_W'(1) : burst_len;
              end
            end
            MODE_RUN_TO_BP: if (req) state_d = ST_RUN;
            default: ;
          endcase
        end

        ST_RUN: begin
          if (!is_free_mode(mode_m)) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            // While adv_q is high the PC has not yet moved past the value it
            // shows, which was already cleared (or is being stepped off), so
            // the compare is ignored on that clock.
            if ((mode_m == MODE_RUN_TO_BP) && bp_any && !adv_q) begin
              state_d  = ST_HALT;
              bp_hit_d = 1'b1;
              bp_idx_d = bp_first;
            end else begin
              adv_d = 1'b1;
            end
          end
        end

        ST_BURST: begin
          if (mode_m != MODE_BURST) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            adv_d = 1'b1;
            rem_d = rem_q - CNT_W'(1);
            if (rem_q <= CNT_W'(1)) state_d = ST_IDLE;
          end
        end

        ST_HALT: begin
          if (!is_free_mode(mode_m)) begin
            state_d = ST_IDLE;
          end else if (req) begin
            // Step off the breakpoint with a single advance, then free-run.
            bp_hit_d = 1'b0;
            adv_d    = 1'b1;
            state_d  = ST_RUN;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      adv_q     <= 1'b0;
      step_q    <= 1'b0;
      rem_q     <= '0;
      bp_hit_q  <= 1'b0;
      bp_idx_q  <= '0;
      adv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      adv_q     <= adv_d;
      step_q    <= step_req;
      rem_q     <= rem_d;
      bp_hit_q  <= bp_hit_d;
      bp_idx_q  <= bp_idx_d;
      adv_cnt_q <= adv_cnt_q + CNT_W'(adv);
    end
  end

  // halt_req masks an already-registered advance in the clock it arrives.
  assign adv       = adv_q & ~halt_req;
  assign running   = (state_q == ST_RUN) || (state_q == ST_BURST);
  assign bp_hit    = bp_hit_q;
  assign bp_idx    = bp_idx_q;
  assign cycle_cnt = adv_cnt_q;

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Randomized scoreboard bench for pipe_step_ctrl.
// Expected adv times are pushed at stimulus time; a negedge monitor pops and compares.
// The pc input follows a +4-per-adv counter, like the datapath PC.
module tb_pipe_step_ctrl;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        step_req;
  logic        halt_req;
  logic [25:0] rate_div;
  logic [15:0] burst_len;
  logic [15:0] pc;
  logic [63:0] bp_addr;
  logic [3:0]  bp_en;
  logic        adv;
  logic        running;
  logic        bp_hit;
  logic [2:0]  bp_idx;
  logic [15:0] cycle_cnt;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   exp_q[$];
  int   exp_cnt     = 0;
  logic adv_seen    = 1'b0;

  pipe_step_ctrl #(.PC_W(16), .CNT_W(16), .DIV_W(26), .NUM_BP(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .step_req  (step_req),
    .halt_req  (halt_req),
    .rate_div  (rate_div),
    .burst_len (burst_len),
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_en     (bp_en),
    .adv       (adv),
    .running   (running),
    .bp_hit    (bp_hit),
    .bp_idx    (bp_idx),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every adv pulse must match the oldest expected timestamp.
  always @(negedge clock) begin : mon
    int t;
    adv_seen = adv;
    if (reset === 1'b1 && adv === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL adv_unexpected: adv pulse at cycle %0d, none expected", cyc);
      end else begin
        t = exp_q.pop_front();
        if (t != cyc) begin
          miscompares++;
          $display("FAIL adv_time: adv pulse at cycle %0d, expected at cycle %0d", cyc, t);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; the PC model steps after any cycle that carried adv.
  task automatic clk1();
    @(posedge clock);
    #1;
    if (adv_seen) pc = pc + 16'd4;
  endtask

  task automatic push_adv(input int t);
    exp_q.push_back(t);
    exp_cnt++;
  endtask

  // Free-running advances entered at cycle e with period r+1, up to cycle x.
  task automatic push_run(input int e, input int r, input int x, input int j0);
    for (int t = e + j0 * (r + 1); t <= x; t += r + 1) push_adv(t);
  endtask

  task automatic drained(input string tag);
    check({tag, "_adv_missing"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, "_cycle_cnt"}, cycle_cnt, exp_cnt & 32'hFFFF);
  endtask

  initial begin
    int k, x, r, n, nn, m, c, jb, tgt, exp_idx;
    logic [15:0] slot_a;
    reset = 1'b0; mode = MODE_STEP; step_req = 1'b0; halt_req = 1'b0;
    rate_div = '0; burst_len = '0; pc = '0; bp_addr = '0; bp_en = '0;

    // Reset values
    repeat (3) clk1();
    check("rst_adv", adv, 0);
    check("rst_running", running, 0);
    check("rst_bp_hit", bp_hit, 0);
    check("rst_bp_idx", bp_idx, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    reset = 1'b1;
    repeat (2) clk1();

    // STEP: one adv per press, held key does not repeat
    for (int i = 0; i < 3; i++) begin
      k = cyc;
      push_adv(k + 1);
      step_req = 1'b1;
      repeat ($urandom_range(1, 4)) begin clk1(); check("step_running", running, 0); end
      step_req = 1'b0;
      repeat ($urandom_range(3, 12)) begin clk1(); check("step_running", running, 0); end
    end
    drained("step");

    // RUN at several rates, exit by switching to STEP
    for (int i = 0; i < 4; i++) begin
      r = (i == 0) ? 4 : (i == 3) ? 0 : $urandom_range(1, 6);
      x = cyc + ((i == 0) ? 51 : $urandom_range(20, 60));
      rate_div = r[25:0];
      k = cyc;
      push_run(k + 1, r, x, 1);
      mode = MODE_RUN;
      clk1();
      while (cyc < x) begin check("run_running", running, 1); clk1(); end
      mode = MODE_STEP;
      clk1(); clk1();
      check("run_exit_running", running, 0);
      drained("run");
    end

    // BURST: len 7 at full rate, len 0, random, and an aborted burst
    for (int i = 0; i < 5; i++) begin
      n = (i == 0) ? 7 : (i == 1) ? 0 : (i == 4) ? 10 : $urandom_range(1, 10);
      r = (i == 0) ? 0 : (i == 4) ? 1 : $urandom_range(0, 3);
      rate_div = r[25:0];
      burst_len = n[15:0];
      mode = MODE_BURST;
      clk1();
      nn = (n == 0) ? 1 : n;
      k = cyc;
      x = (i == 4) ? k + 6 : k + 1 + nn * (r + 1);
      push_run(k + 1, r, x, 1);
      step_req = 1'b1; clk1(); step_req = 1'b0;
      check("burst_running", running, 1);
      while (cyc < x) clk1();
      if (i == 4) mode = MODE_STEP;
      repeat (3) clk1();
      check("burst_done_running", running, 0);
      drained("burst");
    end

    // RUN_TO_BP: halt on breakpoint, lowest enabled slot wins, step off
    for (int i = 0; i < 3; i++) begin
      mode = MODE_STEP; clk1();
      pc = '0;
      r = $urandom_range(1, 3);
      rate_div = r[25:0];
      if (i == 0) begin
        tgt = 16; bp_addr = {4{16'h0010}}; bp_en = 4'b0100;
      end else if (i == 1) begin
        tgt = 16; bp_addr = {16'h0800, 16'h0010, 16'h0010, 16'h0800}; bp_en = 4'b0111;
      end else begin
        tgt = 4 * $urandom_range(1, 8);
        bp_en = 4'($urandom_range(1, 15));
        for (int s = 0; s < 4; s++) begin
          slot_a = ($urandom_range(0, 1) == 1) ? 16'(tgt) : 16'(tgt + 'h1000);
          bp_addr[s*16 +: 16] = slot_a;
        end
        m = $urandom_range(0, 3);
        bp_en[m] = 1'b1;
        bp_addr[m*16 +: 16] = 16'(tgt);
      end
      exp_idx = -1;
      for (int s = 3; s >= 0; s--)
        if (bp_en[s] && bp_addr[s*16 +: 16] == 16'(tgt)) exp_idx = s;

      mode = MODE_RUN_TO_BP;
      clk1();
      k = cyc;
      jb = tgt / 4;
      for (int j = 0; j < jb; j++) push_adv(k + (j + 1) * (r + 1) + 1);
      step_req = 1'b1; clk1(); step_req = 1'b0;
      while (cyc < k + (jb + 1) * (r + 1) + 4) clk1();
      check("bp_hit_set", bp_hit, 1);
      check("bp_idx", bp_idx, exp_idx);
      check("bp_halt_running", running, 0);
      check("bp_pc", pc, tgt);

      m = cyc;
      x = m + 1 + $urandom_range(6, 20);
      push_adv(m + 1);
      push_run(m + 1, r, x, 1);
      step_req = 1'b1; clk1(); step_req = 1'b0;
      check("bp_hit_clear", bp_hit, 0);
      check("bp_resume_running", running, 1);
      while (cyc < x) clk1();
      mode = MODE_STEP;
      clk1(); clk1();
      drained("bp");
    end
    bp_en = '0;

    // halt_req mid-burst with 4 advances remaining, then resume in RUN
    rate_div = 26'd1; burst_len = 16'd8; mode = MODE_BURST;
    clk1();
    k = cyc;
    push_run(k + 1, 1, k + 9, 1);
    step_req = 1'b1; clk1(); step_req = 1'b0;
    while (cyc < k + 10) clk1();
    halt_req = 1'b1; mode = MODE_RUN;
    clk1();
    check("halt_adv", adv, 0);
    check("halt_running", running, 0);
    clk1(); clk1();
    halt_req = 1'b0;
    clk1(); clk1();
    check("halt_hold_running", running, 0);
    m = cyc;
    x = m + 11;
    push_adv(m + 1);
    push_run(m + 1, 1, x, 1);
    step_req = 1'b1; clk1(); step_req = 1'b0;
    check("halt_resume_running", running, 1);
    while (cyc < x) clk1();
    mode = MODE_STEP;
    clk1(); clk1();
    drained("halt");

    // halt_req masks an adv already registered for this clock
    rate_div = 26'd2;
    k = cyc;
    push_adv(k + 4);
    mode = MODE_RUN;
    while (cyc < k + 7) clk1();
    halt_req = 1'b1;
    #1;
    check("halt_masks_adv", adv, 0);
    clk1();
    mode = MODE_STEP; halt_req = 1'b0;
    clk1(); clk1();
    check("halt_mask_running", running, 0);
    drained("halt_mask");

    // Async reset mid-RUN with cycle_cnt at 0x00FF
    reset = 1'b0; clk1(); reset = 1'b1; clk1();
    exp_cnt = 0; exp_q.delete();
    rate_div = '0;
    k = cyc;
    c = k + 257;
    push_run(k + 1, 0, c - 1, 1);
    mode = MODE_RUN;
    while (cyc < c) clk1();
    check("pre_rst_cnt", cycle_cnt, 32'hFF);
    check("pre_rst_adv", adv, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_adv", adv, 0);
    check("async_rst_running", running, 0);
    check("async_rst_cnt", cycle_cnt, 0);
    check("async_rst_bp_hit", bp_hit, 0);
    check("async_rst_bp_idx", bp_idx, 0);
    mode = MODE_STEP;
    clk1(); reset = 1'b1; clk1();
    exp_cnt = 0;
    drained("reset");

    // cycle_cnt wraps 0xFFFF -> 0
    k = cyc;
    c = k + 2 + 65535;
    push_run(k + 1, 0, c + 1, 1);
    mode = MODE_RUN;
    while (cyc < c) clk1();
    check("wrap_top", cycle_cnt, 32'hFFFF);
    clk1();
    check("wrap_zero", cycle_cnt, 0);
    mode = MODE_STEP;
    clk1(); clk1();
    drained("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
